// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: operand width default,
// FSM state encoding and the quotient reported on divide-by-zero.
package div_pkg;

    // Default operand/result width
    localparam int DIV_WIDTH = 32;

    // FSM state encoding (plain constants so older tools can consume it)
    typedef logic [1:0] div_state_t;
    localparam div_state_t ST_IDLE = 2'd0;
    localparam div_state_t ST_CALC = 2'd1;
    localparam div_state_t ST_FIX  = 2'd2;
    localparam div_state_t ST_DONE = 2'd3;

    // Quotient returned when the divisor is zero
    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOTIENT = 32'hFFFF_FFFF;

    // Iteration counter value of the last shift-subtract step
    localparam logic [5:0] LAST_STEP = 6'd31;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration. The quotient register initially
// holds the dividend; each step shifts its top bit into the partial
// remainder and shifts a new quotient bit in at the bottom.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] dvsr,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH:0] shifted;

    // Shift, trial-subtract, and keep the difference only if it is non-negative
    always_comb begin
        shifted = {rem_in, quo_in[WIDTH-1]};
        quo_out = {quo_in[WIDTH-2:0], 1'b0};
        rem_out = shifted[WIDTH-1:0];
        if (shifted >= {1'b0, dvsr}) begin
            rem_out    = shifted[WIDTH-1:0] - dvsr;
            quo_out[0] = 1'b1;
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential 32-step restoring divider: IDLE -> CALC (32 cycles) -> FIX ->
// DONE. Divide-by-zero short-cuts from IDLE straight to DONE.
// Handshake: start is sampled only in IDLE; while busy is high further
// starts are dropped (no queuing); done is a one-cycle pulse during which
// lo_out/hi_out/div_by_zero are valid, and they hold until the next result.
// Optional macro SEQ_DIVIDER_SIGNED_EN selects two's-complement division
// (truncate toward zero, remainder takes the dividend's sign); without it the
// divider is unsigned and FIX just copies the results.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] lo_out,
    output logic [WIDTH-1:0] hi_out,
    output logic             div_by_zero,
    output div_state_t       state_dbg
);

    div_state_t       state;
    logic [5:0]       cnt;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvsr_q;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;
    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic [WIDTH-1:0] lo_fix;
    logic [WIDTH-1:0] hi_fix;

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic quo_neg_q;
    logic rem_neg_q;

    // Operand magnitudes; the most negative value maps onto itself, which is
    // the correct unsigned magnitude
    always_comb begin
        dividend_mag = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
        divisor_mag  = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
    end

    // Re-apply signs to the unsigned results
    always_comb begin
        lo_fix = quo_neg_q ? (~quo_q + 1'b1) : quo_q;
        hi_fix = rem_neg_q ? (~rem_q + 1'b1) : rem_q;
    end

    // Result signs captured with the operands
    always_ff @(posedge clk) begin
        if (clr) begin
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
        end else if (state == ST_IDLE && start) begin
            quo_neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            rem_neg_q <= dividend[WIDTH-1];
        end
    end
`else
    // Unsigned build: operands and results pass through unchanged
    always_comb begin
        dividend_mag = dividend;
        divisor_mag  = divisor;
        lo_fix       = quo_q;
        hi_fix       = rem_q;
    end
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .dvsr    (dvsr_q),
        .rem_out (rem_nxt),
        .quo_out (quo_nxt)
    );

    assign state_dbg = state;

    // Control FSM, working registers and registered outputs
    always_ff @(posedge clk) begin
        if (clr) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvsr_q      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            lo_out      <= '0;
            hi_out      <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        cnt  <= '0;
                        busy <= 1'b1;
                        if (divisor == '0) begin
                            // Results are known immediately
                            lo_out      <= WIDTH'(DIV_ZERO_QUOTIENT);
                            hi_out      <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            state       <= ST_DONE;
                        end else begin
                            rem_q  <= '0;
                            quo_q  <= dividend_mag;
                            dvsr_q <= divisor_mag;
                            state  <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    rem_q <= rem_nxt;
                    quo_q <= quo_nxt;
                    if (cnt == LAST_STEP) begin
                        state <= ST_FIX;
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                ST_FIX: begin
                    lo_out      <= lo_fix;
                    hi_out      <= hi_fix;
                    div_by_zero <= 1'b0;
                    done        <= 1'b1;
                    state       <= ST_DONE;
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider. A cycle-level reference model derived from
// the operation timing (done 34 cycles after start, or 1 cycle for a zero
// divisor) and plain arithmetic is compared every cycle; hand-computed
// results from the vector table pin the model.
module tb_seq_divider;
    import div_pkg::*;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        start = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy;
    logic        done;
    logic [31:0] lo_out;
    logic [31:0] hi_out;
    logic        div_by_zero;
    div_state_t  state_dbg;

    seq_divider dut (
        .clk         (clk),
        .clr         (clr),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .lo_out      (lo_out),
        .hi_out      (hi_out),
        .div_by_zero (div_by_zero),
        .state_dbg   (state_dbg)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    bit          chk_en = 1'b0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    // Reference arithmetic
    function automatic void model_div(input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] q, output logic [31:0] r);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000;
                r = 32'd0;
            end else begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end
`else
            q = a / b;
            r = a % b;
`endif
        end
    endfunction

    // Model: k counts cycles since the accepted start; results appear with done
    int          m_k = 0;
    int          m_lat = 0;
    logic [31:0] m_lo = '0, m_hi = '0, p_lo = '0, p_hi = '0;
    logic        m_dz = 1'b0, p_dz = 1'b0, m_done = 1'b0, m_busy = 1'b0;

    always @(posedge clk) begin
        cyc++;
        if (clr) begin
            m_k  = 0;
            m_lo = '0;
            m_hi = '0;
            m_dz = 1'b0;
        end else if (m_k == 0) begin
            if (start) begin
                model_div(dividend, divisor, p_lo, p_hi);
                p_dz  = (divisor == 32'd0);
                m_lat = p_dz ? 1 : 34;
                m_k   = 1;
            end
        end else if (m_k == m_lat) begin
            m_k = 0;
        end else begin
            m_k++;
        end
        m_done = (m_k != 0 && m_k == m_lat);
        m_busy = (m_k != 0);
        if (m_done) begin
            m_lo = p_lo;
            m_hi = p_hi;
            m_dz = p_dz;
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", busy, m_busy);
            check("done", done, m_done);
            check("lo_out", lo_out, m_lo);
            check("hi_out", hi_out, m_hi);
            check("div_by_zero", div_by_zero, m_dz);
        end
    end

    // Driver tasks
    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #2 launch(a, b);
    endtask

    // Waits for done, checks latency and the hand-computed results in exp_q
    task automatic wait_done(input int lat);
        int n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                n = i;
                break;
            end
        end
        if (n == 0) begin
            check("done_timeout", 32'd0, 32'd1);
            exp_q.delete();
        end else begin
            check("latency", n, lat);
            check("exp_lo", lo_out, exp_q.pop_front());
            check("exp_hi", hi_out, exp_q.pop_front());
            check("exp_dz", div_by_zero, exp_q.pop_front());
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dz;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs[NV];

    initial begin
`ifdef SEQ_DIVIDER_SIGNED_EN
        vecs[0] = '{32'd100, 32'd7, 32'd14, 32'd2, 1'b0};
        vecs[1] = '{32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1};
        vecs[2] = '{32'd10, 32'd5, 32'd2, 32'd0, 1'b0};
        vecs[3] = '{32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0};
        vecs[4] = '{32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0};
        vecs[5] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0};
        vecs[6] = '{32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0};
`else
        vecs[0] = '{32'd100, 32'd7, 32'd14, 32'd2, 1'b0};
        vecs[1] = '{32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1};
        vecs[2] = '{32'd10, 32'd5, 32'd2, 32'd0, 1'b0};
        vecs[3] = '{32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 1'b0};
        vecs[4] = '{32'd5, 32'd9, 32'd0, 32'd5, 1'b0};
        vecs[5] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0};
        vecs[6] = '{32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0};
`endif

        // Reset
        repeat (3) @(posedge clk);
        #2 clr = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_state", state_dbg, ST_IDLE);
        check("rst_lo", lo_out, 32'd0);
        check("rst_hi", hi_out, 32'd0);
        check("rst_busy", busy, 1'b0);

        // Directed table
        for (int v = 0; v < NV; v++) begin
            exp_q.push_back(vecs[v].lo);
            exp_q.push_back(vecs[v].hi);
            exp_q.push_back({31'd0, vecs[v].dz});
            run_op(vecs[v].a, vecs[v].b);
            wait_done(vecs[v].b == 32'd0 ? 1 : 34);
        end

        // start held high through CALC and the DONE cycle: one operation only
        @(posedge clk);
        #2;
        exp_q.push_back(32'd10);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        launch(32'd50, 32'd5);
        begin
            int n = 0;
            for (int i = 1; i <= 40; i++) begin
                start    = 1'b1;
                dividend = $urandom;
                divisor  = $urandom_range(0, 9);
                @(negedge clk);
                if (done === 1'b1) begin
                    n = i;
                    break;
                end
                @(posedge clk);
                #2;
            end
            check("busy_start_latency", n, 34);
            check("busy_start_lo", lo_out, exp_q.pop_front());
            check("busy_start_hi", hi_out, exp_q.pop_front());
            check("busy_start_dz", div_by_zero, exp_q.pop_front());
            @(posedge clk);
            #2 start = 1'b0;
        end

        // clr in the middle of a long operation, then start on the first edge
        @(posedge clk);
        #2 launch(32'hFFFF_FFFF, 32'd3);
        repeat (9) @(posedge clk);
        #2 clr = 1'b1;
        @(posedge clk);
        #2 clr = 1'b0;
        dividend = 32'd9;
        divisor  = 32'd4;
        start    = 1'b1;
        exp_q.push_back(32'd2);
        exp_q.push_back(32'd1);
        exp_q.push_back(32'd0);
        @(negedge clk);
        check("clr_busy", busy, 1'b0);
        check("clr_done", done, 1'b0);
        check("clr_lo", lo_out, 32'd0);
        check("clr_state", state_dbg, ST_IDLE);
        @(posedge clk);
        #2 start = 1'b0;
        wait_done(34);

        // Back-to-back: second start the cycle after done
        exp_q.push_back(32'd333);
        exp_q.push_back(32'd1);
        exp_q.push_back(32'd0);
        run_op(32'd1000, 32'd3);
        wait_done(34);
        exp_q.push_back(32'd7);
        exp_q.push_back(32'd7);
        exp_q.push_back(32'd0);
        run_op(32'd77, 32'd10);
        check("b2b_hold_lo", lo_out, 32'd333);
        check("b2b_hold_busy", busy, 1'b1);
        wait_done(34);

        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
